// File: rtl/audio_pkg.sv
// Shared audio datapath definitions: Q-format helpers, saturation bounds and
// the sequencing states used by the gain/mix blocks.
package audio_pkg;

  localparam int BITSIZE_DFLT = 16;
  localparam int QFRAC        = BITSIZE_DFLT - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    UPD  = 2'd2
  } state_t;

  function automatic int qfrac_of(input int bits);
    return bits - 2;
  endfunction

  function automatic int sat_max(input int bits);
    return (2 ** (bits - 1)) - 1;
  endfunction

  function automatic int sat_min(input int bits);
    return -(2 ** (bits - 1));
  endfunction

endpackage

// File: rtl/gain_splitter4_if.sv
// Sample/gain/output bundle of the 4-way gain splitter; lrclk travels with the
// data because it is sampled on bclk like any other input.
interface gain_splitter4_if
  import audio_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DFLT
);
  logic                      lrclk;
  logic signed [BITSIZE-1:0] in;
  logic signed [BITSIZE-1:0] g1;
  logic signed [BITSIZE-1:0] g2;
  logic signed [BITSIZE-1:0] g3;
  logic signed [BITSIZE-1:0] g4;
  logic signed [BITSIZE-1:0] out1;
  logic signed [BITSIZE-1:0] out2;
  logic signed [BITSIZE-1:0] out3;
  logic signed [BITSIZE-1:0] out4;
  logic                      out_valid;

  modport master (
    output lrclk, in, g1, g2, g3, g4,
    input  out1, out2, out3, out4, out_valid
  );

  modport slave (
    input  lrclk, in, g1, g2, g3, g4,
    output out1, out2, out3, out4, out_valid
  );
endinterface

// File: rtl/q_sat.sv
// Rescales a full-width Q product back to Q1.(BITSIZE-2): arithmetic shift
// (floor, no rounding) followed by a clamp to the BITSIZE signed range.
module q_sat
  import audio_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DFLT
) (
  input  logic signed [2*BITSIZE-1:0] prod_i,
  output logic signed [BITSIZE-1:0]   sat_o
);
  localparam int QF = qfrac_of(BITSIZE);
  localparam int SW = BITSIZE + 2;
  localparam logic signed [SW-1:0] HI = SW'(sat_max(BITSIZE));
  localparam logic signed [SW-1:0] LO = SW'(sat_min(BITSIZE));

  logic signed [SW-1:0] shifted;
  logic                 unused_frac;

  // Dropping the low QF bits of a two's complement value is a floor shift.
  assign shifted     = prod_i[2*BITSIZE-1:QF];
  assign unused_frac = ^prod_i[QF-1:0];

  always_comb begin
    if (shifted > HI) begin
      sat_o = HI[BITSIZE-1:0];
    end else if (shifted < LO) begin
      sat_o = LO[BITSIZE-1:0];
    end else begin
      sat_o = shifted[BITSIZE-1:0];
    end
  end
endmodule

// File: rtl/gain_splitter4.sv
// Fans one mono sample out to four gain-weighted outputs per lrclk frame using
// a single time-multiplexed multiplier; all outputs update together.
module gain_splitter4
  import audio_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DFLT,
  parameter int NCH     = 4
) (
  input  logic              bclk,
  input  logic              reset,
  gain_splitter4_if.slave   bus
);
  state_t                      state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic                        lrclk_q, lrclk_d;
  logic                        fs;
  logic signed [BITSIZE-1:0]   in_s_q, in_s_d;
  logic signed [BITSIZE-1:0]   g_s_q [NCH];
  logic signed [BITSIZE-1:0]   g_s_d [NCH];
  logic signed [2*BITSIZE-1:0] prod_q, prod_d;
  logic signed [BITSIZE-1:0]   res_q [NCH];
  logic signed [BITSIZE-1:0]   res_d [NCH];
  logic signed [BITSIZE-1:0]   out_q [NCH];
  logic signed [BITSIZE-1:0]   out_d [NCH];
  logic                        out_valid_q, out_valid_d;
  logic signed [BITSIZE-1:0]   sat_res;

  q_sat #(.BITSIZE(BITSIZE)) u_q_sat (
    .prod_i (prod_q),
    .sat_o  (sat_res)
  );

  always_comb begin
    fs          = bus.lrclk & ~lrclk_q;
    lrclk_d     = bus.lrclk;
    state_d     = state_q;
    idx_d       = idx_q;
    in_s_d      = in_s_q;
    g_s_d       = g_s_q;
    prod_d      = prod_q;
    res_d       = res_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    case (state_q)
      // Multiply for channel idx while the previous channel's product is rescaled.
      MUL: begin
        if (idx_q < 3'd4) begin
          prod_d = (2*BITSIZE)'(in_s_q) * (2*BITSIZE)'(g_s_q[idx_q[1:0]]);
          idx_d  = idx_q + 3'd1;
        end
        if (idx_q != 3'd0) begin
          res_d[idx_q[1:0] - 2'd1] = sat_res;
        end
        if (idx_q == 3'd4) begin
          state_d = UPD;
        end
      end
      UPD: begin
        out_d       = res_q;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: ;
    endcase

    // A new frame always wins over a partial one; UPD above still completes.
    if (fs) begin
      in_s_d   = bus.in;
      g_s_d[0] = bus.g1;
      g_s_d[1] = bus.g2;
      g_s_d[2] = bus.g3;
      g_s_d[3] = bus.g4;
      state_d  = MUL;
      idx_d    = 3'd0;
    end
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      lrclk_q     <= 1'b1;
      out_valid_q <= 1'b0;
      for (int k = 0; k < NCH; k++) out_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lrclk_q     <= lrclk_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  always_ff @(posedge bclk) begin
    in_s_q <= in_s_d;
    g_s_q  <= g_s_d;
    prod_q <= prod_d;
    res_q  <= res_d;
  end

  assign bus.out1      = out_q[0];
  assign bus.out2      = out_q[1];
  assign bus.out3      = out_q[2];
  assign bus.out4      = out_q[3];
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_gain_splitter4.sv
// Bench for gain_splitter4: frame-level reference model with a per-cycle
// output compare, plus directed frames with hand-computed results.
module tb_gain_splitter4;
  localparam int BS = 16;

  logic bclk = 1'b0;
  logic reset;
  always #5 bclk = ~bclk;

  gain_splitter4_if #(.BITSIZE(BS)) bus ();

  gain_splitter4 #(.BITSIZE(BS), .NCH(4)) dut (
    .bclk  (bclk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // sat(floor(x*g / 2^14)) in plain integer arithmetic.
  function automatic int model_ch(input int x, input int g);
    longint p, q;
    p = longint'(x) * longint'(g);
    q = p / 16384;
    if (p < 0 && (p % 16384) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  // Reference: each frame start schedules its results 6 edges later; a newer
  // frame start or a reset before that point cancels the pending frame.
  bit  m_lr = 1'b1;
  bit  m_pend = 1'b0;
  int  cyc = 0;
  int  m_due = 0;
  int  m_val [4];
  int  e_out [4] = '{0, 0, 0, 0};
  bit  e_vld = 1'b0;
  bit  chk_en = 1'b0;
  int  vld_cnt = 0;

  always @(posedge bclk) begin
    cyc++;
    if (reset) begin
      m_lr   = 1'b1;
      m_pend = 1'b0;
      e_vld  = 1'b0;
      e_out  = '{0, 0, 0, 0};
    end else begin
      e_vld = 1'b0;
      if (m_pend && cyc == m_due) begin
        e_out  = m_val;
        e_vld  = 1'b1;
        m_pend = 1'b0;
      end
      if (bus.lrclk && !m_lr) begin
        m_pend   = 1'b1;
        m_due    = cyc + 6;
        m_val[0] = model_ch(int'(bus.in), int'(bus.g1));
        m_val[1] = model_ch(int'(bus.in), int'(bus.g2));
        m_val[2] = model_ch(int'(bus.in), int'(bus.g3));
        m_val[3] = model_ch(int'(bus.in), int'(bus.g4));
      end
      m_lr = bus.lrclk;
    end
  end

  always @(negedge bclk) begin
    if (chk_en) begin
      chk("out_valid", int'(bus.out_valid), int'(e_vld));
      chk("out1", int'(bus.out1), e_out[0]);
      chk("out2", int'(bus.out2), e_out[1]);
      chk("out3", int'(bus.out3), e_out[2]);
      chk("out4", int'(bus.out4), e_out[3]);
      if (bus.out_valid) vld_cnt++;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge bclk);
  endtask

  task automatic setin(input int x, input int a, input int b, input int c, input int d);
    bus.in = BS'(x);
    bus.g1 = BS'(a);
    bus.g2 = BS'(b);
    bus.g3 = BS'(c);
    bus.g4 = BS'(d);
  endtask

  task automatic frame(input int x, input int a, input int b, input int c, input int d);
    setin(x, a, b, c, d);
    bus.lrclk = 1'b1;
    wait_n(32);
    bus.lrclk = 1'b0;
    wait_n(32);
  endtask

  function automatic int rnd16();
    case ($urandom_range(0, 7))
      0:       return -32768;
      1:       return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    int base;
    reset     = 1'b1;
    bus.lrclk = 1'b0;
    setin(0, 0, 0, 0, 0);
    wait_n(1);
    chk_en = 1'b1;
    wait_n(2);
    chk("rst_out1", int'(bus.out1), 0);
    chk("rst_out4", int'(bus.out4), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    reset = 1'b0;
    wait_n(4);

    chk("pin_half", model_ch(1000, 8192), 500);
    chk("pin_neg", model_ch(1000, -16384), -1000);
    chk("pin_trunc_m1", model_ch(-1, 8192), -1);
    chk("pin_trunc_3", model_ch(3, 8192), 1);
    chk("pin_sat_hi", model_ch(-32768, -32768), 32767);
    chk("pin_sat_lo", model_ch(-32768, 32767), -32768);

    // Basic weighting and latency
    setin(1000, 16384, 8192, -16384, 0);
    bus.lrclk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_n(1);
      chk("t1_vld_timing", int'(bus.out_valid), (i == 6) ? 1 : 0);
    end
    chk("t1_out1", int'(bus.out1), 1000);
    chk("t1_out2", int'(bus.out2), 500);
    chk("t1_out3", int'(bus.out3), -1000);
    chk("t1_out4", int'(bus.out4), 0);
    wait_n(24);
    bus.lrclk = 1'b0;
    wait_n(32);

    // Saturation
    frame(30000, 32767, 32767, 0, 0);
    chk("t2_sat_a", int'(bus.out1), 32767);
    frame(-32768, -32768, 32767, 0, 0);
    chk("t2_sat_b", int'(bus.out1), 32767);
    chk("t2_sat_c", int'(bus.out2), -32768);

    // Truncation toward -inf
    frame(-1, 8192, 0, 0, 0);
    chk("t3_m1", int'(bus.out1), -1);
    frame(1, 8192, 0, 0, 0);
    chk("t3_p1", int'(bus.out1), 0);
    frame(3, 8192, 0, 0, 0);
    chk("t3_p3", int'(bus.out1), 1);

    // Input changes after the frame start are ignored
    setin(500, 16384, -8192, 4096, 32767);
    bus.lrclk = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_n(1);
      setin(rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
    end
    wait_n(3);
    chk("t4_hold1", int'(bus.out1), 500);
    chk("t4_hold2", int'(bus.out2), -250);
    chk("t4_hold3", int'(bus.out3), 125);
    chk("t4_hold4", int'(bus.out4), 999);
    bus.lrclk = 1'b0;
    wait_n(32);

    // Restart: second frame start three edges after the first
    setin(1200, 16384, 16384, 16384, 16384);
    bus.lrclk = 1'b1;
    wait_n(2);
    bus.lrclk = 1'b0;
    setin(-700, 16384, -16384, 8192, 100);
    wait_n(1);
    bus.lrclk = 1'b1;
    for (int i = 3; i < 13; i++) begin
      wait_n(1);
      chk("t4_restart_vld", int'(bus.out_valid), (i == 9) ? 1 : 0);
    end
    chk("t4_rs_out1", int'(bus.out1), -700);
    chk("t4_rs_out2", int'(bus.out2), 700);
    chk("t4_rs_out3", int'(bus.out3), -350);
    chk("t4_rs_out4", int'(bus.out4), -5);
    bus.lrclk = 1'b0;
    wait_n(32);

    // Reset mid-sequence, released while lrclk is high
    setin(2000, 16384, 16384, 16384, 16384);
    bus.lrclk = 1'b1;
    wait_n(4);
    reset = 1'b1;
    wait_n(5);
    chk("t5_rst_out1", int'(bus.out1), 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_n(1);
      chk("t5_no_frame", int'(bus.out_valid), 0);
    end
    chk("t5_held_out1", int'(bus.out1), 0);
    bus.lrclk = 1'b0;
    wait_n(2);
    frame(2000, 16384, 8192, 4096, -16384);
    chk("t5_after_out1", int'(bus.out1), 2000);
    chk("t5_after_out4", int'(bus.out4), -2000);

    // Randomized frames
    base = vld_cnt;
    for (int f = 0; f < 100; f++) begin
      frame(rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
    end
    chk("t6_frames", vld_cnt - base, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
